train_sequencer: RTL and testbench
==================================

Name: train_sequencer

Overview:
- Hardware replacement for the DNN training-loop control, sitting between the training-data memories and the DNN top.
- Runs a per-training-case block cycle of CPC clocks and walks case index and epoch index.
- Generates the input/ideal-output chunk select fed to the DNN each clock.
- Scores each case from the serial actual/ideal output bits and keeps total and moving-window accuracy counters.

Parameters:
- CPC, 18, clocks per block cycle (n0*fo0/z0 + 2); 2 pipeline clocks plus CPC-2 feed clocks.
- CASES_W, 16, width of case index and case-count config.
- EPOCH_W, 8, width of epoch index and epoch-count config.
- RECENT, 1000, moving-accuracy window length in cases.
- TOTAL_W, 24, width of total_correct.

Ports:
- clk  in  1  clock
- reset  in  1  async active-high reset
- start  in  1  one-clock pulse; latches config, begins training
- abort  in  1  stop training at next clock
- cfg_cases  in  CASES_W  cases per epoch
- cfg_epochs  in  EPOCH_W  number of epochs
- a_bit  in  1  thresholded DNN output for the current neuron
- y_bit  in  1  ideal output for the current neuron (y_out)
- busy  out  1  high in RUN
- done  out  1  high in DONE
- cycle_index  out  $clog2(CPC)  position in block, 0..CPC-1
- cycle_clk  out  1  high when cycle_index==0 in RUN
- feed_sel  out  $clog2(CPC-2)  chunk select = (cycle_index+CPC-4) mod (CPC-2)
- case_idx  out  CASES_W  current training case address
- epoch_idx  out  EPOCH_W  current epoch, 0-based
- case_done  out  1  one-clock pulse at end of each block
- case_correct  out  1  result of last completed case; valid with case_done, held after
- epoch_done  out  1  one-clock pulse, coincident with case_done of the last case in an epoch
- recent_correct  out  $clog2(RECENT+1)  correct count over last RECENT cases
- total_correct  out  TOTAL_W  correct count since start

Behaviour:
- Reset (async): state IDLE; all outputs 0; window shift register cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE/DONE + start:
  - Latch cfg_cases and cfg_epochs.
  - Clear case_idx, epoch_idx, cycle_index, recent_correct, total_correct and the window.
  - If either config value is 0, go to DONE; else go to RUN.
- RUN clocking:
  - cycle_index increments every clock and wraps at CPC-1 → 0.
  - feed_sel is combinational from cycle_index. Values for CPC=18: index 0→14, 1→15, 2→0, 17→15.
- Scoring:
  - Internal case_ok is set to 1 at cycle_index 0.
  - For cycle_index ≥ 2: if a_bit != y_bit, case_ok is cleared.
  - At cycle_index 0 and 1, a_bit and y_bit are ignored.
- End of block (cycle_index==CPC-1):
  - case_correct <= final case_ok, including this clock's compare.
  - case_done pulses.
  - total_correct += case_correct, saturating.
  - Window: shift in case_correct; recent_correct += new − bit shifted out. Before RECENT cases have completed, the bit shifted out is 0.
  - case_idx increments. If case_idx == cfg_cases−1, it wraps to 0, epoch_done pulses and epoch_idx increments.
  - If that was the last case of epoch cfg_epochs−1: go to DONE; epoch_idx holds cfg_epochs−1; cycle_index returns to 0.
- Latency: case_done/case_correct appear on the clock after the final compare edge, i.e. on the edge that wraps cycle_index to 0.
- DONE: done=1, busy=0; counters and scores held until next start.
- abort in RUN: go to IDLE next clock; cycle_index=0; in-flight case not scored; counters held.
- Simultaneous events:
  - abort beats end-of-block.
  - start while in RUN is ignored.
  - start and abort together in IDLE: start wins.
- Reset mid-run: immediate return to IDLE with all outputs 0.

Decomposition:
- Shared package:
  - State enum {IDLE, RUN, DONE}.
  - Default CPC computed from the n/fo/z layer arrays.
  - Index width functions.
- One sub-module: acc_window (RECENT-deep bit shift register with incremental popcount, synchronous clear, shift-enable). The codebase's existing cycle_block_counter is not reused, because it cannot be held or cleared by the FSM.

Test Plan:
- Reset then start with cfg_cases=3, cfg_epochs=2 → busy=1 next clock; case_idx sequence 0,1,2,0,1,2 with 18 clocks each; epoch_done at clocks 54 and 108; done=1 after 108 clocks.
- Feed sweep over one block → feed_sel=14,15,0,1,…,15; cycle_clk high only at index 0.
- a_bit=y_bit all block except a single mismatch at index 2, then at index 17 of the next block → case_correct=0 for both; total_correct unchanged. Mismatches at index 0/1 only → case_correct=1.
- RECENT=4, outcome pattern 1,1,0,1,1,1 → recent_correct=1,2,2,3,3,3; total_correct=5.
- abort at cycle_index 9 of case 1 → IDLE next clock; total_correct excludes case 1; done stays 0. Then start → counters cleared.
- start with cfg_cases=0 → DONE immediately; no case_done pulses. Asserting reset mid-RUN → all outputs 0 asynchronously.

Source files
------------

// File: rtl/train_sequencer_pkg.sv
// rtl/train_sequencer_pkg.sv - shared types and sizing helpers for the training sequencer
package train_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    // First-layer geometry of the DNN; one block feeds n0*fo0/z0 chunks plus 2 pipeline clocks.
    localparam int LAYER_N  [2] = '{16, 8};
    localparam int LAYER_FO [2] = '{4, 4};
    localparam int LAYER_Z  [2] = '{4, 4};

    localparam int DEFAULT_CPC = LAYER_N[0] * LAYER_FO[0] / LAYER_Z[0] + 2;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/train_sequencer_acc_window.sv
// rtl/train_sequencer_acc_window.sv - bit history shift register with running popcount
module train_sequencer_acc_window #(
    parameter int DEPTH = 1000,
    parameter int CNT_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             shift_en,
    input  logic             bit_in,
    output logic [CNT_W-1:0] count
);

    logic [DEPTH-1:0] hist;

    // Count tracks popcount(hist) incrementally: add the entering bit, drop the leaving one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist  <= '0;
            count <= '0;
        end else if (clear) begin
            hist  <= '0;
            count <= '0;
        end else if (shift_en) begin
            hist  <= {hist[DEPTH-2:0], bit_in};
            count <= count + CNT_W'(bit_in) - CNT_W'(hist[DEPTH-1]);
        end
    end

endmodule

// File: rtl/train_sequencer.sv
// rtl/train_sequencer.sv - training-loop block/case/epoch sequencer with accuracy scoring
module train_sequencer
    import train_sequencer_pkg::*;
#(
    parameter int CPC     = DEFAULT_CPC,
    parameter int CASES_W = 16,
    parameter int EPOCH_W = 8,
    parameter int RECENT  = 1000,
    parameter int TOTAL_W = 24
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         abort,
    input  logic [CASES_W-1:0]           cfg_cases,
    input  logic [EPOCH_W-1:0]           cfg_epochs,
    input  logic                         a_bit,
    input  logic                         y_bit,
    output logic                         busy,
    output logic                         done,
    output logic [idx_w(CPC)-1:0]        cycle_index,
    output logic                         cycle_clk,
    output logic [idx_w(CPC-2)-1:0]      feed_sel,
    output logic [CASES_W-1:0]           case_idx,
    output logic [EPOCH_W-1:0]           epoch_idx,
    output logic                         case_done,
    output logic                         case_correct,
    output logic                         epoch_done,
    output logic [$clog2(RECENT+1)-1:0]  recent_correct,
    output logic [TOTAL_W-1:0]           total_correct
);

    localparam int CI_W = idx_w(CPC);
    localparam int FS_W = idx_w(CPC-2);
    localparam int RC_W = $clog2(RECENT+1);
    localparam logic [CI_W-1:0] LAST_IDX = CI_W'(CPC-1);
    localparam logic [CI_W:0]   FEED_OFS = (CI_W+1)'(CPC-4);
    localparam logic [CI_W:0]   FEED_MOD = (CI_W+1)'(CPC-2);

    state_t               state_q, state_d;
    logic [CASES_W-1:0]   cfg_cases_q;
    logic [EPOCH_W-1:0]   cfg_epochs_q;
    logic                 case_ok, ok_now;
    logic                 start_go, end_blk, last_case, last_epoch;
    logic [CI_W:0]        feed_sum, feed_wrap;

    assign start_go   = start && (state_q != RUN);
    assign end_blk    = (state_q == RUN) && (cycle_index == LAST_IDX);
    assign last_case  = (case_idx == cfg_cases_q - CASES_W'(1));
    assign last_epoch = (epoch_idx == cfg_epochs_q - EPOCH_W'(1));

    // The two pipeline clocks carry no valid output bits, so they restart the case score.
    assign ok_now = (cycle_index < CI_W'(2)) ? 1'b1 : (case_ok && (a_bit == y_bit));

    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign cycle_clk = busy && (cycle_index == '0);

    assign feed_sum  = {1'b0, cycle_index} + FEED_OFS;
    assign feed_wrap = (feed_sum >= FEED_MOD) ? feed_sum - FEED_MOD : feed_sum;
    assign feed_sel  = busy ? FS_W'(feed_wrap) : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: begin
                if (start)
                    state_d = (cfg_cases == '0 || cfg_epochs == '0) ? DONE : RUN;
            end
            RUN: begin
                if (abort)
                    state_d = IDLE;
                else if (end_blk && last_case && last_epoch)
                    state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cfg_cases_q   <= '0;
            cfg_epochs_q  <= '0;
            cycle_index   <= '0;
            case_idx      <= '0;
            epoch_idx     <= '0;
            case_ok       <= 1'b0;
            case_done     <= 1'b0;
            case_correct  <= 1'b0;
            epoch_done    <= 1'b0;
            total_correct <= '0;
        end else begin
            case_done  <= 1'b0;
            epoch_done <= 1'b0;
            if (start_go) begin
                cfg_cases_q   <= cfg_cases;
                cfg_epochs_q  <= cfg_epochs;
                cycle_index   <= '0;
                case_idx      <= '0;
                epoch_idx     <= '0;
                total_correct <= '0;
            end else if (state_q == RUN) begin
                if (abort) begin
                    cycle_index <= '0;
                end else begin
                    case_ok <= ok_now;
                    if (end_blk) begin
                        cycle_index  <= '0;
                        case_done    <= 1'b1;
                        case_correct <= ok_now;
                        if (ok_now && total_correct != '1)
                            total_correct <= total_correct + TOTAL_W'(1);
                        if (last_case) begin
                            case_idx   <= '0;
                            epoch_done <= 1'b1;
                            if (!last_epoch)
                                epoch_idx <= epoch_idx + EPOCH_W'(1);
                        end else begin
                            case_idx <= case_idx + CASES_W'(1);
                        end
                    end else begin
                        cycle_index <= cycle_index + CI_W'(1);
                    end
                end
            end
        end
    end

    train_sequencer_acc_window #(
        .DEPTH (RECENT),
        .CNT_W (RC_W)
    ) u_window (
        .clk      (clk),
        .rst      (reset),
        .clear    (start_go),
        .shift_en (end_blk && !abort),
        .bit_in   (ok_now),
        .count    (recent_correct)
    );

endmodule

// File: tb/tb_train_sequencer.sv
// tb/tb_train_sequencer.sv - scoreboard bench for train_sequencer
module tb_train_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] cfg_cases = '0;
    logic [7:0]  cfg_epochs = '0;
    logic        a_bit = 1'b0;
    logic        y_bit = 1'b0;
    logic        busy, done, cycle_clk, case_done, case_correct, epoch_done;
    logic [4:0]  cycle_index;
    logic [3:0]  feed_sel;
    logic [15:0] case_idx;
    logic [7:0]  epoch_idx;
    logic [2:0]  recent_correct;
    logic [23:0] total_correct;

    train_sequencer #(
        .CPC     (18),
        .CASES_W (16),
        .EPOCH_W (8),
        .RECENT  (4),
        .TOTAL_W (24)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .abort          (abort),
        .cfg_cases      (cfg_cases),
        .cfg_epochs     (cfg_epochs),
        .a_bit          (a_bit),
        .y_bit          (y_bit),
        .busy           (busy),
        .done           (done),
        .cycle_index    (cycle_index),
        .cycle_clk      (cycle_clk),
        .feed_sel       (feed_sel),
        .case_idx       (case_idx),
        .epoch_idx      (epoch_idx),
        .case_done      (case_done),
        .case_correct   (case_correct),
        .epoch_done     (epoch_done),
        .recent_correct (recent_correct),
        .total_correct  (total_correct)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ok;
        logic        ed;
        logic [15:0] cidx;
        logic [7:0]  eidx;
        logic [23:0] tot;
        logic [2:0]  rec;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int   n_pass = 0;
    int   n_total = 0;
    int   feed_tbl [18] = '{14, 15, 0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic expect_case(input logic ok, input logic ed, input int cidx, input int eidx,
                               input int tot, input int rec);
        exp_t e;
        e.ok = ok; e.ed = ed; e.cidx = 16'(cidx); e.eidx = 8'(eidx);
        e.tot = 24'(tot); e.rec = 3'(rec);
        exp_q.push_back(e);
    endtask

    task automatic do_start(input int c, input int e);
        cfg_cases  = 16'(c);
        cfg_epochs = 8'(e);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Drives one 18-clock block; mm0/mm1 are the indices where a_bit disagrees with y_bit.
    task automatic run_case(input int mm0, input int mm1, input bit sweep, input bit poke);
        for (int i = 0; i < 18; i++) begin
            y_bit = 1'($urandom_range(0, 1));
            a_bit = y_bit ^ ((i == mm0) || (i == mm1));
            if (sweep) begin
                check("cycle_index", 32'(cycle_index), i);
                check("feed_sel", 32'(feed_sel), feed_tbl[i]);
                check("cycle_clk", 32'(cycle_clk), (i == 0) ? 1 : 0);
            end
            start = poke && (i == 5);
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!reset && case_done) begin
            if (exp_q.size() == 0) begin
                check("case_done_unexpected", 1, 0);
            end else begin
                cur = exp_q.pop_front();
                check("case_correct", 32'(case_correct), 32'(cur.ok));
                check("epoch_done", 32'(epoch_done), 32'(cur.ed));
                check("case_idx", 32'(case_idx), 32'(cur.cidx));
                check("epoch_idx", 32'(epoch_idx), 32'(cur.eidx));
                check("total_correct", 32'(total_correct), 32'(cur.tot));
                check("recent_correct", 32'(recent_correct), 32'(cur.rec));
            end
        end
        if (epoch_done && !case_done) check("epoch_done_alone", 1, 0);
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_total);
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_case_idx", 32'(case_idx), 0);
        check("rst_total", 32'(total_correct), 0);
        check("rst_feed_sel", 32'(feed_sel), 0);
        reset = 1'b0;
        @(negedge clk);

        // 3 cases x 2 epochs, all correct; a start pulse mid-run must be ignored
        do_start(3, 2);
        check("a_busy", 32'(busy), 1);
        check("a_case_idx0", 32'(case_idx), 0);
        expect_case(1, 0, 1, 0, 1, 1);
        expect_case(1, 0, 2, 0, 2, 2);
        expect_case(1, 1, 0, 1, 3, 3);
        expect_case(1, 0, 1, 1, 4, 4);
        expect_case(1, 0, 2, 1, 5, 4);
        expect_case(1, 1, 0, 1, 6, 4);
        run_case(-1, -1, 1, 0);
        cfg_cases = '0;
        cfg_epochs = '0;
        run_case(-1, -1, 0, 1);
        for (int k = 0; k < 4; k++) run_case(-1, -1, 0, 0);
        check("a_done_108", 32'(done), 1);
        check("a_busy_end", 32'(busy), 0);

        // moving window with outcome pattern 1,1,0,1,1,1
        do_start(6, 1);
        expect_case(1, 0, 1, 0, 1, 1);
        expect_case(1, 0, 2, 0, 2, 2);
        expect_case(0, 0, 3, 0, 2, 2);
        expect_case(1, 0, 4, 0, 3, 3);
        expect_case(1, 0, 5, 0, 4, 3);
        expect_case(1, 1, 0, 0, 5, 3);
        run_case(-1, -1, 0, 0);
        run_case(-1, -1, 0, 0);
        run_case(9, -1, 0, 0);
        for (int k = 0; k < 3; k++) run_case(-1, -1, 0, 0);

        // mismatch at first and last scored index, then only in the pipeline clocks
        do_start(3, 1);
        expect_case(0, 0, 1, 0, 0, 0);
        expect_case(0, 0, 2, 0, 0, 0);
        expect_case(1, 1, 0, 0, 1, 1);
        run_case(2, -1, 0, 0);
        run_case(17, -1, 0, 0);
        run_case(0, 1, 0, 0);
        repeat (3) @(negedge clk);
        check("b_done_hold", 32'(done), 1);
        check("b_correct_hold", 32'(case_correct), 1);
        check("b_total_hold", 32'(total_correct), 1);

        // abort at index 9 of case 1
        do_start(3, 1);
        expect_case(1, 0, 1, 0, 1, 1);
        run_case(-1, -1, 0, 0);
        for (int i = 0; i < 9; i++) begin
            y_bit = 1'($urandom_range(0, 1));
            a_bit = y_bit;
            @(negedge clk);
        end
        check("d_idx9", 32'(cycle_index), 9);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("d_abort_busy", 32'(busy), 0);
        check("d_abort_done", 32'(done), 0);
        check("d_abort_cycle", 32'(cycle_index), 0);
        check("d_abort_case_idx", 32'(case_idx), 1);
        check("d_abort_total", 32'(total_correct), 1);

        // start together with abort from IDLE: start wins and clears counters
        cfg_cases = 16'd1;
        cfg_epochs = 8'd1;
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("d_restart_busy", 32'(busy), 1);
        check("d_restart_case_idx", 32'(case_idx), 0);
        check("d_restart_total", 32'(total_correct), 0);
        check("d_restart_recent", 32'(recent_correct), 0);
        expect_case(1, 1, 0, 0, 1, 1);
        run_case(-1, -1, 0, 0);
        check("d_done", 32'(done), 1);

        // zero cases goes straight to DONE without scoring
        do_start(0, 5);
        check("e_zero_done", 32'(done), 1);
        check("e_zero_busy", 32'(busy), 0);
        repeat (40) @(negedge clk);
        check("e_zero_case_idx", 32'(case_idx), 0);

        // reset mid-run clears everything without waiting for a clock edge
        do_start(2, 1);
        expect_case(1, 0, 1, 0, 1, 1);
        run_case(-1, -1, 0, 0);
        repeat (5) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("e_rst_busy", 32'(busy), 0);
        check("e_rst_cycle", 32'(cycle_index), 0);
        check("e_rst_case_idx", 32'(case_idx), 0);
        check("e_rst_total", 32'(total_correct), 0);
        check("e_rst_recent", 32'(recent_correct), 0);
        check("e_rst_correct", 32'(case_correct), 0);
        check("e_rst_feed_sel", 32'(feed_sel), 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        check("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
